// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 instruction-fetch stage: fetch FSM encoding and
// architectural defaults for the reset vector and the bubble instruction word.
package mips32_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_REQ  = 2'd0;
  localparam fetch_state_t S_WAIT = 2'd1;
  localparam fetch_state_t S_HOLD = 2'd2;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT     = 32'h0000_0000;

endpackage

// File: rtl/mips32_fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master) and
// the instruction memory (slave).
interface mips32_fetch_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              Imem_Req_Valid;
  logic              Imem_Req_Ready;
  logic [ADDR_W-1:0] Imem_Addr;
  logic              Imem_Rsp_Valid;
  logic [31:0]       Imem_Rsp_Data;

  modport master (
    output Imem_Req_Valid,
    output Imem_Addr,
    input  Imem_Req_Ready,
    input  Imem_Rsp_Valid,
    input  Imem_Rsp_Data
  );

  modport slave (
    input  Imem_Req_Valid,
    input  Imem_Addr,
    output Imem_Req_Ready,
    output Imem_Rsp_Valid,
    output Imem_Rsp_Data
  );
endinterface

// File: rtl/mips32_ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds every field, and an enabled
// cycle with nothing to load inserts a bubble.
module mips32_ifid_reg
  import mips32_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              load,
  input  logic [31:0]       instr_in,
  input  logic [ADDR_W-1:0] pc_plus_4_in,
  output logic              valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_plus_4
);

  logic              valid_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_plus_4_q;

  // PC+4 is left untouched on flush and bubble; only a real load replaces it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q     <= 1'b0;
      instr_q     <= NOP_WORD;
      pc_plus_4_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
    end else if (enable) begin
      if (load) begin
        valid_q     <= 1'b1;
        instr_q     <= instr_in;
        pc_plus_4_q <= pc_plus_4_in;
      end else begin
        valid_q <= 1'b0;
        instr_q <= NOP_WORD;
      end
    end
  end

  assign valid     = valid_q;
  assign instr     = instr_q;
  assign pc_plus_4 = pc_plus_4_q;

endmodule

// File: rtl/mips32_fetch_stage.sv
// MIPS32 IF stage: PC, single-outstanding imem handshake, wrong-path kill and IF/ID register.
// Optional perf counters Fetch_Count/Stall_Count when MIPS32_FETCH_PERF_EN is defined.
module mips32_fetch_stage
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned ADDR_W       = 32,
  parameter logic [31:0] NOP_WORD     = NOP_WORD_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 PC_Enable,
  input  logic                 PCSrc_MEM,
  input  logic [ADDR_W-1:0]    Branch_Dest_MEM,
  mips32_fetch_stage_if.master imem,
  output logic [ADDR_W-1:0]    PC_IF,
  output logic [ADDR_W-1:0]    Next_PC_IF,
  output logic [31:0]          Instruction_ID,
  output logic [ADDR_W-1:0]    PC_Plus_4_ID,
  output logic                 Valid_ID,
  output logic                 Fetch_Stall
`ifdef MIPS32_FETCH_PERF_EN
  ,
  output logic [31:0]          Fetch_Count,
  output logic [31:0]          Stall_Count
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [31:0]       hold_q, hold_d;
  logic              rsp_live;
  logic              deliver;
  logic [31:0]       deliver_word;
  logic [ADDR_W-1:0] pc_plus_4;

  assign pc_plus_4           = pc_q + ADDR_W'(4);
  assign imem.Imem_Req_Valid = (state_q == S_REQ) && !PCSrc_MEM;
  assign imem.Imem_Addr      = pc_q;
  assign rsp_live            = (state_q == S_WAIT) && imem.Imem_Rsp_Valid && !kill_q;
  assign deliver             = PC_Enable && !PCSrc_MEM && (rsp_live || (state_q == S_HOLD));
  assign deliver_word        = (state_q == S_HOLD) ? hold_q : imem.Imem_Rsp_Data;
  assign Fetch_Stall         = PC_Enable && !rsp_live && (state_q != S_HOLD);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    hold_d  = hold_q;
    if (PCSrc_MEM) begin
      pc_d = Branch_Dest_MEM & ~ADDR_W'(3);
      case (state_q)
        // The outstanding response is wrong-path: drop it now or mark it for dropping.
        S_WAIT: begin
          if (imem.Imem_Rsp_Valid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem.Imem_Req_Ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem.Imem_Rsp_Valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (PC_Enable) begin
              state_d = S_REQ;
            end else begin
              hold_d  = imem.Imem_Rsp_Data;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (PC_Enable) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
      if (deliver) pc_d = pc_plus_4;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_VECTOR[ADDR_W-1:0];
      kill_q  <= 1'b0;
      hold_q  <= NOP_WORD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      hold_q  <= hold_d;
    end
  end

  assign PC_IF      = pc_q;
  assign Next_PC_IF = pc_d;

  mips32_ifid_reg #(
    .ADDR_W   (ADDR_W),
    .NOP_WORD (NOP_WORD)
  ) u_ifid (
    .Clk          (Clk),
    .Reset        (Reset),
    .enable       (PC_Enable),
    .flush        (PCSrc_MEM),
    .load         (deliver),
    .instr_in     (deliver_word),
    .pc_plus_4_in (pc_plus_4),
    .valid        (Valid_ID),
    .instr        (Instruction_ID),
    .pc_plus_4    (PC_Plus_4_ID)
  );

`ifdef MIPS32_FETCH_PERF_EN
  logic [31:0] fetch_count_q, stall_count_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (deliver && (fetch_count_q != '1))     fetch_count_q <= fetch_count_q + 32'd1;
      if (Fetch_Stall && (stall_count_q != '1)) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign Fetch_Count = fetch_count_q;
  assign Stall_Count = stall_count_q;
`endif

endmodule

// File: tb/tb_mips32_fetch_stage.sv
// Self-checking bench for mips32_fetch_stage: directed scenarios plus a random run,
// all checked against a transaction-level model of the fetch stage and a latency-based imem.
module tb_mips32_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RV  = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PC_Enable = 1'b0;
  logic        PCSrc_MEM = 1'b0;
  logic [31:0] Branch_Dest_MEM = '0;
  logic [31:0] PC_IF, Next_PC_IF, Instruction_ID, PC_Plus_4_ID;
  logic        Valid_ID, Fetch_Stall;
`ifdef MIPS32_FETCH_PERF_EN
  logic [31:0] Fetch_Count, Stall_Count;
`endif

  mips32_fetch_stage_if #(.ADDR_W(32)) imem ();

  mips32_fetch_stage dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .PC_Enable       (PC_Enable),
    .PCSrc_MEM       (PCSrc_MEM),
    .Branch_Dest_MEM (Branch_Dest_MEM),
    .imem            (imem),
    .PC_IF           (PC_IF),
    .Next_PC_IF      (Next_PC_IF),
    .Instruction_ID  (Instruction_ID),
    .PC_Plus_4_ID    (PC_Plus_4_ID),
    .Valid_ID        (Valid_ID),
    .Fetch_Stall     (Fetch_Stall)
`ifdef MIPS32_FETCH_PERF_EN
    ,
    .Fetch_Count     (Fetch_Count),
    .Stall_Count     (Stall_Count)
`endif
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 1;

  // Reference model: PC, one outstanding request (possibly wrong-path), a parked word, IF/ID.
  logic [31:0] m_pc, m_hw, m_instr, m_pc4, m_fetch, m_stalls;
  logic        m_busy, m_stale, m_held, m_valid;

  // Memory: one pending response, due a fixed number of cycles after acceptance.
  logic        mem_pending = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_due = 0;

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_instr, obs_pc4;

  initial begin
    imem.Imem_Req_Ready = 1'b0;
    imem.Imem_Rsp_Valid = 1'b0;
    imem.Imem_Rsp_Data  = '0;
  end

  task automatic model_reset();
    m_pc = RV; m_busy = 0; m_stale = 0; m_held = 0; m_hw = NOP;
    m_valid = 0; m_instr = NOP; m_pc4 = '0; m_fetch = '0; m_stalls = '0;
  endtask

  task automatic apply_reset();
    Reset = 1'b1; PC_Enable = 0; PCSrc_MEM = 0; Branch_Dest_MEM = '0;
    imem.Imem_Req_Ready = 0; imem.Imem_Rsp_Valid = 0;
    mem_pending = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    cyc++;
  endtask

  // One clock cycle: drive at edge+1, compare at edge+4, advance model, wait for next edge.
  task automatic cycle(input logic en, input logic br, input logic [31:0] dest, input logic rdy);
    logic exp_req, accepted, got, good, deliver, exp_stall;
    logic [31:0] word, npc, rdata;
    PC_Enable = en; PCSrc_MEM = br; Branch_Dest_MEM = dest; imem.Imem_Req_Ready = rdy;
    if (mem_pending && mem_due == cyc) begin
      imem.Imem_Rsp_Valid = 1'b1;
      imem.Imem_Rsp_Data  = mem_addr + 32'h100;
      mem_pending = 1'b0;
    end else begin
      imem.Imem_Rsp_Valid = 1'b0;
      imem.Imem_Rsp_Data  = $urandom;
    end
    rdata = imem.Imem_Rsp_Data;
    #3;
    exp_req   = !m_busy && !m_held && !br;
    accepted  = exp_req && rdy;
    got       = m_busy && imem.Imem_Rsp_Valid;
    good      = got && !m_stale;
    exp_stall = en && !good && !m_held;
    deliver   = !br && en && (good || m_held);
    word      = m_held ? m_hw : rdata;
    npc       = br ? {dest[31:2], 2'b00} : (deliver ? m_pc + 32'd4 : m_pc);

    obs_req = imem.Imem_Req_Valid; obs_addr = imem.Imem_Addr; obs_pc = PC_IF;
    obs_valid = Valid_ID; obs_instr = Instruction_ID; obs_pc4 = PC_Plus_4_ID;

    n_vec++;
    if (imem.Imem_Req_Valid !== exp_req) begin
      n_err++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem.Imem_Req_Valid, exp_req);
    end
    n_vec++;
    if (imem.Imem_Addr !== m_pc) begin
      n_err++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem.Imem_Addr, m_pc);
    end
    n_vec++;
    if (PC_IF !== m_pc) begin
      n_err++; $display("FAIL pc_if cyc=%0d got=%h exp=%h", cyc, PC_IF, m_pc);
    end
    n_vec++;
    if (Next_PC_IF !== npc) begin
      n_err++; $display("FAIL next_pc cyc=%0d got=%h exp=%h", cyc, Next_PC_IF, npc);
    end
    n_vec++;
    if (Valid_ID !== m_valid) begin
      n_err++; $display("FAIL valid_id cyc=%0d got=%b exp=%b", cyc, Valid_ID, m_valid);
    end
    n_vec++;
    if (Instruction_ID !== m_instr) begin
      n_err++; $display("FAIL instr_id cyc=%0d got=%h exp=%h", cyc, Instruction_ID, m_instr);
    end
    n_vec++;
    if (PC_Plus_4_ID !== m_pc4) begin
      n_err++; $display("FAIL pc4_id cyc=%0d got=%h exp=%h", cyc, PC_Plus_4_ID, m_pc4);
    end
    n_vec++;
    if (Fetch_Stall !== exp_stall) begin
      n_err++; $display("FAIL fetch_stall cyc=%0d got=%b exp=%b", cyc, Fetch_Stall, exp_stall);
    end
`ifdef MIPS32_FETCH_PERF_EN
    n_vec++;
    if (Fetch_Count !== m_fetch) begin
      n_err++; $display("FAIL fetch_count cyc=%0d got=%0d exp=%0d", cyc, Fetch_Count, m_fetch);
    end
    n_vec++;
    if (Stall_Count !== m_stalls) begin
      n_err++; $display("FAIL stall_count cyc=%0d got=%0d exp=%0d", cyc, Stall_Count, m_stalls);
    end
`endif

    if (accepted) begin
      mem_pending = 1'b1; mem_addr = m_pc; mem_due = cyc + lat;
    end
    if (br) begin
      if (m_busy) begin
        if (got) begin m_busy = 0; m_stale = 0; end
        else m_stale = 1;
      end
      m_held = 0; m_valid = 0; m_instr = NOP;
    end else begin
      if (got) begin
        m_busy = 0;
        if (m_stale) m_stale = 0;
        else if (!en) begin m_held = 1; m_hw = rdata; end
      end else if (m_held && en) begin
        m_held = 0;
      end
      if (en) begin
        if (deliver) begin m_valid = 1; m_instr = word; m_pc4 = m_pc + 32'd4; end
        else begin m_valid = 0; m_instr = NOP; end
      end
    end
    if (accepted) m_busy = 1;
    if (deliver && m_fetch != '1) m_fetch++;
    if (exp_stall && m_stalls != '1) m_stalls++;
    m_pc = npc;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #2;
    n_vec++;
    if (PC_IF !== RV || Next_PC_IF !== RV) begin
      n_err++; $display("FAIL reset_pc got=%h/%h exp=%h", PC_IF, Next_PC_IF, RV);
    end
    n_vec++;
    if (Valid_ID !== 1'b0 || Instruction_ID !== NOP || PC_Plus_4_ID !== 32'h0) begin
      n_err++; $display("FAIL reset_ifid got=%b/%h/%h exp=0/%h/0", Valid_ID, Instruction_ID,
                        PC_Plus_4_ID, NOP);
    end
    n_vec++;
    if (imem.Imem_Req_Valid !== 1'b1) begin
      n_err++; $display("FAIL reset_req got=%b exp=1", imem.Imem_Req_Valid);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    logic [31:0] addrs[$];
    logic [31:0] instrs[$];
    logic [6:0]  vpat;
    apply_reset();
    lat = 1;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      if (obs_req) addrs.push_back(obs_addr);
      if (obs_valid) instrs.push_back(obs_instr);
      vpat[i] = obs_valid;
    end
    n_vec++;
    if (addrs.size() < 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
      n_err++; $display("FAIL basic_addr_seq got %0d reqs first=%h exp 0,4,8", addrs.size(),
                        (addrs.size() > 0) ? addrs[0] : 32'hx);
    end
    n_vec++;
    if (instrs.size() != 3 || instrs[0] !== 32'h100 || instrs[1] !== 32'h104 ||
        instrs[2] !== 32'h108) begin
      n_err++; $display("FAIL basic_instr_seq got %0d words exp 100,104,108", instrs.size());
    end
    n_vec++;
    if (vpat !== 7'b1010100) begin
      n_err++; $display("FAIL basic_valid_pattern got=%b exp=%b", vpat, 7'b1010100);
    end
  endtask

  task automatic test_hold();
    apply_reset();
    lat = 1;
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      n_vec++;
      if (obs_valid !== 1'b1 || obs_instr !== 32'h100 || obs_pc !== 32'h4) begin
        n_err++; $display("FAIL hold_frozen i=%0d got=%b/%h pc=%h exp=1/100 pc=4", i, obs_valid,
                          obs_instr, obs_pc);
      end
    end
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    n_vec++;
    if (obs_valid !== 1'b1 || obs_instr !== 32'h104 || obs_pc !== 32'h8) begin
      n_err++; $display("FAIL hold_release got=%b/%h pc=%h exp=1/104 pc=8", obs_valid, obs_instr,
                        obs_pc);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] first_addr, first_instr;
    logic        have_addr, have_instr, early_valid;
    apply_reset();
    lat = 3;
    early_valid = 0;
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, 32'h40, 1'b0);
    early_valid |= obs_valid;
    cycle(1'b1, 1'b0, '0, 1'b0);
    early_valid |= obs_valid;
    cycle(1'b1, 1'b0, '0, 1'b0);
    early_valid |= obs_valid;
    lat = 1;
    have_addr = 0; have_instr = 0; first_addr = '0; first_instr = '0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      if (obs_req && !have_addr) begin have_addr = 1; first_addr = obs_addr; end
      if (obs_valid && !have_instr) begin have_instr = 1; first_instr = obs_instr; end
    end
    n_vec++;
    if (!have_addr || first_addr !== 32'h40) begin
      n_err++; $display("FAIL redirect_addr got=%h exp=00000040", first_addr);
    end
    n_vec++;
    if (early_valid || !have_instr || first_instr !== 32'h140) begin
      n_err++; $display("FAIL redirect_first_instr got=%h early=%b exp=00000140", first_instr,
                        early_valid);
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    lat = 1;
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, 32'h81, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    n_vec++;
    if (obs_pc !== 32'h80 || obs_valid !== 1'b0 || obs_req !== 1'b1) begin
      n_err++; $display("FAIL same_cycle got pc=%h valid=%b req=%b exp pc=80 valid=0 req=1",
                        obs_pc, obs_valid, obs_req);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    lat = 1;
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0);
    lat = 3;
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    // Async reset while the request for 0x4 is outstanding; its response arrives after release.
    Reset = 1'b1;
    imem.Imem_Rsp_Valid = 1'b0;
    #2;
    n_vec++;
    if (PC_IF !== RV || Valid_ID !== 1'b0 || Instruction_ID !== NOP || PC_Plus_4_ID !== 32'h0) begin
      n_err++; $display("FAIL reset_mid pc=%h valid=%b instr=%h pc4=%h exp reset values", PC_IF,
                        Valid_ID, Instruction_ID, PC_Plus_4_ID);
    end
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    cyc++;
    lat = 1;
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    n_vec++;
    if (obs_req !== 1'b1 || obs_addr !== RV || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_stale got req=%b addr=%h valid=%b exp 1/%h/0", obs_req,
                        obs_addr, obs_valid, RV);
    end
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_wrap();
    apply_reset();
    lat = 1;
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    n_vec++;
    if (obs_pc !== 32'h0 || obs_pc4 !== 32'h0 || obs_valid !== 1'b1 || obs_instr !== 32'hFC) begin
      n_err++; $display("FAIL wrap got pc=%h pc4=%h valid=%b instr=%h exp 0/0/1/000000fc", obs_pc,
                        obs_pc4, obs_valid, obs_instr);
    end
  endtask

  task automatic test_random();
    logic        en, br, rdy;
    logic [31:0] dest;
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      lat  = int'($urandom_range(1, 3));
      en   = ($urandom % 4) != 0;
      br   = ($urandom % 10) == 0;
      rdy  = ($urandom % 3) != 0;
      dest = $urandom;
      cycle(en, br, dest, rdy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_redirect();
    test_same_cycle();
    test_reset_mid_wait();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
